// File: rtl/nbit_bidirectional_piso_serializer_pkg.sv
// rtl/nbit_bidirectional_piso_serializer_pkg.sv - shared encodings for the PISO serializer and its receiver
package nbit_bidirectional_piso_serializer_pkg;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/nbit_bidirectional_piso_serializer.sv
// rtl/nbit_bidirectional_piso_serializer.sv - parallel-in serial-out shifter, LSB- or MSB-first per frame
module nbit_bidirectional_piso_serializer
  import nbit_bidirectional_piso_serializer_pkg::*;
#(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [MSB-1:0] indata,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic           direction,
  input  logic           enable,
  output logic           outdata,
  output logic           out_valid,
  output logic           last,
  output logic           done
);

  localparam int CW = $clog2(MSB);
  localparam logic [CW-1:0] LAST_IDX = CW'(MSB - 1);

  state_e         state_q;
  logic [MSB-1:0] shift_q;
  logic [MSB-1:0] shift_d;
  logic           dir_q;
  logic [CW-1:0]  count_q;
  logic           done_q;

  logic in_shift;
  logic last_bit;
  logic beat;
  logic load_acc;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (count_q == LAST_IDX);
  assign beat     = in_shift && enable;
  assign load_acc = load_valid && load_ready;

  // A new word may slip in on the final beat so frames run back-to-back.
  assign load_ready = !in_shift || (last_bit && enable);

  always_comb begin
    shift_d = shift_q;
    if (dir_q == DIR_MSB_FIRST) begin
      shift_d = {shift_q[MSB-2:0], 1'b0};
    end else begin
      shift_d = {1'b0, shift_q[MSB-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shift_q <= '0;
      dir_q   <= DIR_LSB_FIRST;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= beat && last_bit;
      if (load_acc) begin
        state_q <= SHIFT;
        shift_q <= indata;
        dir_q   <= direction;
        count_q <= '0;
      end else if (beat) begin
        shift_q <= shift_d;
        if (last_bit) begin
          state_q <= IDLE;
          count_q <= '0;
        end else begin
          count_q <= count_q + CW'(1);
        end
      end
    end
  end

  assign outdata   = in_shift && ((dir_q == DIR_MSB_FIRST) ? shift_q[MSB-1] : shift_q[0]);
  assign out_valid = in_shift;
  assign last      = last_bit;
  assign done      = done_q;

endmodule
